// File: rtl/sha_round_ctrl_pkg.sv
// Shared constants and state encoding for the SHA-256 round controller.
// Also used by the hash datapath and the W-schedule blocks.
package sha_round_ctrl_pkg;

    localparam int ROUNDS      = 64;
    localparam int IDX_W       = 6;
    localparam int SCHED_START = 16;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(ROUNDS - 1);
    localparam logic [IDX_W-1:0] SCHED_IDX = IDX_W'(SCHED_START);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_WAIT_BLK,
        S_LOAD,
        S_ROUND,
        S_UPDATE,
        S_DONE
    } state_t;

endpackage

// File: rtl/sha_round_ctrl.sv
// SHA-256 control unit: sequences a message block by block through the rounds.
// Optional SHA_CTRL_ABORT_EN adds a synchronous i_abort that returns to IDLE.
module sha_round_ctrl
    import sha_round_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_start,
    input  logic             i_blk_valid,
    input  logic             i_blk_last,
    output logic             o_blk_ready,
    output logic             o_init_h,
    output logic             o_load_wv,
    output logic             o_round_en,
    output logic [IDX_W-1:0] o_round_idx,
    output logic             o_w_sel_sched,
    output logic             o_upd_h,
    output logic             o_busy,
    output logic             o_digest_valid,
`ifdef SHA_CTRL_ABORT_EN
    input  logic             i_abort,
`endif
    input  logic             i_digest_ready
);

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] cnt_q;
    logic [IDX_W-1:0] cnt_d;
    logic             last_q;
    logic             last_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_start) state_d = S_INIT;
            end
            S_INIT: begin
                state_d = S_WAIT_BLK;
            end
            S_WAIT_BLK: begin
                if (i_blk_valid) begin
                    last_d  = i_blk_last;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_ROUND;
            end
            S_ROUND: begin
                // Wrap explicitly at the last round, not at 2^IDX_W.
                if (cnt_q == LAST_IDX) begin
                    cnt_d   = '0;
                    state_d = S_UPDATE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_UPDATE: begin
                state_d = last_q ? S_DONE : S_WAIT_BLK;
            end
            S_DONE: begin
                if (i_digest_ready) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
`ifdef SHA_CTRL_ABORT_EN
        // Abort overrides everything; H is left untouched.
        if (i_abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
`endif
    end

    logic in_round;

    assign in_round       = (state_q == S_ROUND);
    assign o_blk_ready    = (state_q == S_WAIT_BLK);
    assign o_init_h       = (state_q == S_INIT);
    assign o_load_wv      = (state_q == S_LOAD);
    assign o_round_en     = in_round;
    assign o_round_idx    = in_round ? cnt_q : '0;
    assign o_w_sel_sched  = in_round && (cnt_q >= SCHED_IDX);
    assign o_upd_h        = (state_q == S_UPDATE);
    assign o_busy         = (state_q != S_IDLE);
    assign o_digest_valid = (state_q == S_DONE);

endmodule
